// File: rtl/riscv_decode_stage_if.sv
// Shared decode-stage constants and the fetch/execute handshake bundle around the decode stage.
// The slave modport is the decode stage itself; the master modport is its environment.
package riscv_constants;

  typedef enum logic [2:0] {
    OP2_RS2 = 3'd0,
    OP2_IMI = 3'd1,
    OP2_IMS = 3'd2,
    OP2_IMJ = 3'd3,
    OP2_IMU = 3'd4
  } op2_sel_e;

endpackage

interface riscv_decode_stage_if #(
  parameter int unsigned WORD_LENGTH = 32
);
  import riscv_constants::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            in_inst;
  logic [WORD_LENGTH-1:0] in_pc;

  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_LENGTH-1:0] out_pc;
  op2_sel_e               op2_sel;
  logic [4:0]             rs1_addr;
  logic [4:0]             rs2_addr;
  logic [4:0]             rd_addr;
  logic [WORD_LENGTH-1:0] imm_i_sext;
  logic [WORD_LENGTH-1:0] imm_s_sext;
  logic [WORD_LENGTH-1:0] imm_b_sext;
  logic [WORD_LENGTH-1:0] imm_j_sext;
  logic [WORD_LENGTH-1:0] imm_u_sext;
  logic                   illegal;

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, op2_sel, rs1_addr, rs2_addr, rd_addr,
    output imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_sext, illegal
  );

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, op2_sel, rs1_addr, rs2_addr, rd_addr,
    input  imm_i_sext, imm_s_sext, imm_b_sext, imm_j_sext, imm_u_sext, illegal
  );

endinterface

// File: rtl/riscv_decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word, captured into a 2-entry skid
// buffer (head + skid) so in_ready is registered and one instruction per cycle is sustained.
module riscv_decode_stage #(
  parameter int unsigned WORD_LENGTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  flush,
  riscv_decode_stage_if.slave  bus
);
  import riscv_constants::*;

  typedef struct packed {
    logic [WORD_LENGTH-1:0] pc;
    op2_sel_e               op2_sel;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [WORD_LENGTH-1:0] imm_i;
    logic [WORD_LENGTH-1:0] imm_s;
    logic [WORD_LENGTH-1:0] imm_b;
    logic [WORD_LENGTH-1:0] imm_j;
    logic [WORD_LENGTH-1:0] imm_u;
    logic                   illegal;
  } entry_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  entry_t dec;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  state_e state_q, state_d;
  logic   in_ready_q, out_valid_q;
  logic   in_hs, out_hs;

  // Immediates are produced for every format; execute picks one through op2_sel.
  always_comb begin
    dec         = '0;
    dec.pc      = bus.in_pc;
    dec.rs1     = bus.in_inst[19:15];
    dec.rs2     = bus.in_inst[24:20];
    dec.rd      = bus.in_inst[11:7];
    dec.imm_i   = WORD_LENGTH'($signed(bus.in_inst[31:20]));
    dec.imm_s   = WORD_LENGTH'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
    dec.imm_b   = WORD_LENGTH'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                        bus.in_inst[11:8], 1'b0}));
    dec.imm_j   = WORD_LENGTH'($signed({bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                                        bus.in_inst[30:21], 1'b0}));
    dec.imm_u   = WORD_LENGTH'({bus.in_inst[31:12], 12'b0});
    dec.op2_sel = OP2_RS2;
    dec.illegal = 1'b0;
    unique case (bus.in_inst[6:0])
      7'b0110011, 7'b1100011:            dec.op2_sel = OP2_RS2;
      7'b0010011, 7'b0000011, 7'b1100111: dec.op2_sel = OP2_IMI;
      7'b0100011:                        dec.op2_sel = OP2_IMS;
      7'b1101111:                        dec.op2_sel = OP2_IMJ;
      7'b0110111, 7'b0010111:            dec.op2_sel = OP2_IMU;
      default:                           dec.illegal = 1'b1;
    endcase
  end

  assign in_hs  = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_hs) begin
          head_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_hs && out_hs) begin
          head_d = dec;
        end else if (in_hs) begin
          skid_d  = dec;
          state_d = StFull;
        end else if (out_hs) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (out_hs) begin
          head_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // A redirect drops everything; a same-cycle consume was still a valid handoff.
    if (flush) state_d = StEmpty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != StFull);
      out_valid_q <= (state_d != StEmpty);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_pc     = head_q.pc;
  assign bus.op2_sel    = head_q.op2_sel;
  assign bus.rs1_addr   = head_q.rs1;
  assign bus.rs2_addr   = head_q.rs2;
  assign bus.rd_addr    = head_q.rd;
  assign bus.imm_i_sext = head_q.imm_i;
  assign bus.imm_s_sext = head_q.imm_s;
  assign bus.imm_b_sext = head_q.imm_b;
  assign bus.imm_j_sext = head_q.imm_j;
  assign bus.imm_u_sext = head_q.imm_u;
  assign bus.illegal    = head_q.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Bench for riscv_decode_stage: directed vectors plus random traffic against a queue-based
// FIFO model that decodes instructions arithmetically from the RV32I field layout.
module tb_riscv_decode_stage;
  import riscv_constants::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   dut_pops = 0;
  txn_t q[$];

  riscv_decode_stage_if #(.WORD_LENGTH(32)) bus ();

  riscv_decode_stage #(.WORD_LENGTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void ref_dec(input logic [31:0] inst, output logic [31:0] op,
                                  output logic ill, output logic [31:0] ii, output logic [31:0] is,
                                  output logic [31:0] ib, output logic [31:0] ij,
                                  output logic [31:0] iu);
    int v;
    ill = 1'b0;
    case (inst[6:0])
      7'h33, 7'h63:        op = 32'(OP2_RS2);
      7'h13, 7'h03, 7'h67: op = 32'(OP2_IMI);
      7'h23:               op = 32'(OP2_IMS);
      7'h6F:               op = 32'(OP2_IMJ);
      7'h37, 7'h17:        op = 32'(OP2_IMU);
      default: begin
        op  = 32'(OP2_RS2);
        ill = 1'b1;
      end
    endcase
    v = int'(inst[31:20]);
    if (inst[31]) v -= 4096;
    ii = v;
    v = int'(inst[31:25]) * 32 + int'(inst[11:7]);
    if (inst[31]) v -= 4096;
    is = v;
    v = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    if (inst[31]) v -= 4096;
    ib = v;
    v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
    if (inst[31]) v -= 1048576;
    ij = v;
    iu = inst & 32'hFFFF_F000;
  endfunction

  task automatic cmp_outputs();
    logic [31:0] op, ii, is, ib, ij, iu;
    logic        ill;
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      ref_dec(q[0].inst, op, ill, ii, is, ib, ij, iu);
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("op2_sel", 32'(bus.op2_sel), op);
      chk("illegal", 32'(bus.illegal), 32'(ill));
      chk("rs1", 32'(bus.rs1_addr), 32'(q[0].inst[19:15]));
      chk("rs2", 32'(bus.rs2_addr), 32'(q[0].inst[24:20]));
      chk("rd", 32'(bus.rd_addr), 32'(q[0].inst[11:7]));
      chk("imm_i", bus.imm_i_sext, ii);
      chk("imm_s", bus.imm_s_sext, is);
      chk("imm_b", bus.imm_b_sext, ib);
      chk("imm_j", bus.imm_j_sext, ij);
      chk("imm_u", bus.imm_u_sext, iu);
    end
  endtask

  // One cycle: drive at the negedge, compare before the posedge, advance the model at it.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    logic in_hs, out_hs;
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    cmp_outputs();
    if (bus.out_valid && ordy) dut_pops++;
    in_hs  = v && (q.size() < 2);
    out_hs = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (out_hs) void'(q.pop_front());
      if (in_hs) q.push_back('{inst: inst, pc: pc});
    end
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_op2_sel", 32'(bus.op2_sel), 32'(OP2_RS2));
    chk("rst_illegal", 32'(bus.illegal), 32'd0);
    chk("rst_regs", {17'd0, bus.rs1_addr, bus.rs2_addr, bus.rd_addr}, 32'd0);
    chk("rst_imm_i", bus.imm_i_sext, 32'd0);
    chk("rst_imm_s", bus.imm_s_sext, 32'd0);
    chk("rst_imm_b", bus.imm_b_sext, 32'd0);
    chk("rst_imm_j", bus.imm_j_sext, 32'd0);
    chk("rst_imm_u", bus.imm_u_sext, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check_reset_vals();
    @(negedge clk);
  endtask

  // Holds one known vector at the head and checks it against hand-derived constants.
  task automatic probe(input string tag, input logic [31:0] inst, input logic [31:0] exp_op,
                       input int which, input logic [31:0] exp_imm, input logic [4:0] exp_rd,
                       input logic exp_ill);
    logic [31:0] imm;
    step(1'b1, inst, 32'h100, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #1;
    case (which)
      0: imm = bus.imm_i_sext;
      1: imm = bus.imm_s_sext;
      2: imm = bus.imm_b_sext;
      3: imm = bus.imm_j_sext;
      default: imm = bus.imm_u_sext;
    endcase
    chk({tag, "_op2"}, 32'(bus.op2_sel), exp_op);
    chk({tag, "_imm"}, imm, exp_imm);
    chk({tag, "_rd"}, 32'(bus.rd_addr), 32'(exp_rd));
    chk({tag, "_ill"}, 32'(bus.illegal), 32'(exp_ill));
    @(negedge clk);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [6:0] ops [9] = '{7'h33, 7'h63, 7'h13, 7'h03, 7'h67, 7'h23, 7'h6F, 7'h37, 7'h17};
  logic [31:0] r_inst;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Decode vectors
    probe("addi", 32'hFFF00093, 32'(OP2_IMI), 0, 32'hFFFF_FFFF, 5'd1, 1'b0);
    probe("sw", 32'h0020A423, 32'(OP2_IMS), 1, 32'd8, 5'd8, 1'b0);
    probe("jal", 32'hFFDFF06F, 32'(OP2_IMJ), 3, 32'hFFFF_FFFC, 5'd0, 1'b0);
    probe("lui", 32'h123452B7, 32'(OP2_IMU), 4, 32'h1234_5000, 5'd5, 1'b0);
    probe("add", 32'h002081B3, 32'(OP2_RS2), 0, 32'd2, 5'd3, 1'b0);
    probe("beq", 32'hFE208CE3, 32'(OP2_RS2), 2, 32'hFFFF_FFF8, 5'd25, 1'b0);
    probe("bad", 32'h0000007F, 32'(OP2_RS2), 0, 32'd0, 5'd0, 1'b1);

    // Backpressure: third offer waits until the first pop frees a slot
    step(1'b1, 32'h00100093, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h00200093, 32'h4, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'h8, 1'b0, 1'b0);
    step(1'b1, 32'h00300093, 32'h8, 1'b1, 1'b0);
    chk("bp_pc_after_pop", bus.out_pc, 32'h4);
    step(1'b1, 32'h00300093, 32'h8, 1'b1, 1'b0);
    chk("bp_pc_third", bus.out_pc, 32'h8);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full rate: 100 instructions, both sides always ready
    dut_pops = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 32'h00000013 | (32'(i) << 20), 32'(i * 4), 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("full_rate_pops", 32'(dut_pops), 32'd100);

    // Flush while FULL with an offer pending
    step(1'b1, 32'h00500093, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h00600093, 32'h24, 1'b0, 1'b0);
    step(1'b1, 32'h00700093, 32'h28, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    step(1'b1, 32'h00800093, 32'h2C, 1'b0, 1'b0);
    chk("flush_resume_pc", bus.out_pc, 32'h2C);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset while FULL
    step(1'b1, 32'h00900093, 32'h30, 1'b0, 1'b0);
    step(1'b1, 32'h00A00093, 32'h34, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    do_reset();
    step(1'b1, 32'h00B00093, 32'h38, 1'b0, 1'b0);
    chk("post_rst_first_pc", bus.out_pc, 32'h38);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      r_inst = $urandom();
      if ($urandom_range(0, 9) != 0) r_inst[6:0] = ops[$urandom_range(0, 8)];
      step(1'($urandom_range(0, 1)), r_inst, $urandom(), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
# riscv_decode_stage

Decode stage of the kana-riscv pipeline. It accepts fetched instruction words over a valid/ready handshake and decodes each one into the `OP2_SEL` operand-2 select, the sign-extended immediates, register addresses and an illegal flag. It presents these through a 2-entry skid buffer to the execute stage, where they drive the operand-2 multiplexer directly. The buffer sustains one instruction per cycle with a registered `in_ready` and supports a synchronous pipeline flush.

## Interface
- `WORD_LENGTH`, 32, datapath width. Only 32 is supported (RV32I).
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: discard all buffered instructions (branch/jump redirect).
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage can accept an instruction this cycle.
- `in_inst` in 32: instruction word.
- `in_pc` in WORD_LENGTH: instruction address.
- `out_valid` out 1: decoded entry available.
- `out_ready` in 1: execute consumes the entry.
- `out_pc` out WORD_LENGTH: PC passed through unchanged.
- `op2_sel` out OP2_SEL: operand-2 select, from `riscv_constants`.
- `rs1_addr`, `rs2_addr`, `rd_addr` out 5 each: `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `imm_i_sext`, `imm_s_sext`, `imm_b_sext`, `imm_j_sext`, `imm_u_sext` out WORD_LENGTH each: immediates.
- `illegal` out 1: opcode is not RV32I base.

## Operation
- Decode is combinational on `in_inst`; its results are captured into the buffer on acceptance.
- `op2_sel` by `inst[6:0]`:
  - 0110011 (OP) and 1100011 (BRANCH) give `OP2_RS2`.
  - 0010011 (OP-IMM), 0000011 (LOAD) and 1100111 (JALR) give `OP2_IMI`.
  - 0100011 (STORE) gives `OP2_IMS`.
  - 1101111 (JAL) gives `OP2_IMJ`.
  - 0110111 (LUI) and 0010111 (AUIPC) give `OP2_IMU`.
  - Any other opcode gives `OP2_RS2` with `illegal=1`.
- Immediates, computed for every instruction regardless of format:
  - I = sext(`inst[31:20]`).
  - S = sext({`inst[31:25]`,`inst[11:7]`}).
  - B = sext({`inst[31]`,`inst[7]`,`inst[30:25]`,`inst[11:8]`,0}).
  - J = sext({`inst[31]`,`inst[19:12]`,`inst[20]`,`inst[30:21]`,0}).
  - U = {`inst[31:12]`, 12'b0}.
  - Sign source is always `inst[31]`.
- Buffer: head and skid entry registers plus an occupancy state.
  - EMPTY:
    - `in_valid` goes to ONE.
  - ONE:
    - in and out handshakes together stay ONE (head replaced).
    - in only goes to FULL (new entry to skid).
    - out only goes to EMPTY.
  - FULL:
    - out handshake goes to ONE; skid moves to head.
    - No input is accepted.
- `in_ready` = (state != FULL). It depends only on registered state, not on `out_ready`.
- `out_valid` = (state != EMPTY). All outputs come from the head entry.
- Order is strict FIFO. No entry is dropped or duplicated except by `flush`.
- `flush`: the next state is EMPTY. An input handshake in the same cycle is discarded. An output handshake in the same cycle is still a legal consume.
- `rst` has priority over `flush`.

## Timing
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, with `out_valid=1`.
- Throughput: one instruction per cycle while `out_ready=1` continuously.
- Output stability: while `out_valid=1` and `out_ready=0`, every output holds its value.
- Reset: after a `rst` edge, state is EMPTY and `out_valid=0`, so `in_ready=1`. Data outputs read 0, `op2_sel=OP2_RS2` and `illegal=0`.
- Reset mid-operation has the same effect; buffered entries are lost.
- Flush: `out_valid=0` the cycle after the flush edge and `in_ready=1`. Acceptance resumes that cycle.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.

## Test plan
- **Decode:** stream with `out_ready=1`:
  - `addi x1,x0,-1` (0xFFF00093): `OP2_IMI`, `imm_i_sext=0xFFFFFFFF`, `rd_addr=1`.
  - `sw x2,8(x1)` (0x0020A423): `OP2_IMS`, `imm_s_sext=8`.
  - `jal x0,-4` (0xFFDFF06F): `OP2_IMJ`, `imm_j_sext=0xFFFFFFFC`.
  - `lui x5,0x12345` (0x123452B7): `OP2_IMU`, `imm_u_sext=0x12345000`.
  - `add` (0x002081B3): `OP2_RS2`.
- **Branch:** `beq x1,x2,-8` (0xFE208CE3) gives `OP2_RS2`, `imm_b_sext=0xFFFFFFF8`. Opcode 0x0000007F gives `illegal=1`, `op2_sel=OP2_RS2`.
- **Backpressure:** three back-to-back valids with `out_ready=0`:
  - Two are accepted; `in_ready=0` after the second.
  - Raise `out_ready`: outputs appear in order, one per cycle.
  - Third is accepted the cycle after the first pop; PCs are 0x0, 0x4, 0x8.
- **Full rate:** 100 sequential instructions with both sides always ready. Exactly 100 outputs, 1 cycle latency, no bubbles.
- **Flush:** in FULL with `in_valid=1`, assert `flush` one cycle. Next cycle `out_valid=0` and `in_ready=1`; the offered instruction never appears.
- **Reset:** assert `rst` while FULL. After release all outputs read reset values and the next accepted instruction is the first output.
